instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the control unit.
- Holds the PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small in-order FIFO and presents them to decode, split into opcode, func and the register/immediate fields.
- Handles decode back-pressure and PC redirects (branch/jump) by flushing and discarding stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem request issue, in-order response
// buffer with stale-response dropping after redirects, and field split for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    output logic [15:0] imm
);

    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_buf_instr [DEPTH];
    logic [31:0]   r_buf_pc    [DEPTH];
    logic [31:0]   r_ifq       [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_ifq_rd;
    logic [PW-1:0] r_ifq_wr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic w_credit;
    logic w_req;
    logic w_rsp;
    logic w_keep;
    logic w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == P_LAST) ? '0 : p + PW'(1);
    endfunction

    // Buffered plus in-flight never exceeds DEPTH, so a returning response always has a slot.
    assign w_credit       = ({1'b0, r_count} + {1'b0, r_outstanding}) < {1'b0, C_DEPTH};
    assign imem_req_valid = !rst && !redirect_valid && w_credit;
    assign imem_req_addr  = r_pc & ~32'd3;

    assign w_req  = imem_req_valid && imem_req_ready;
    assign w_rsp  = imem_rsp_valid && (r_outstanding != '0);
    assign w_keep = w_rsp && (r_drop == '0) && !redirect_valid;
    assign w_pop  = if_valid && id_ready && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_ifq_rd      <= '0;
            r_ifq_wr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            if (w_req) r_ifq_wr <= ptr_inc(r_ifq_wr);
            if (w_rsp) r_ifq_rd <= ptr_inc(r_ifq_rd);
            r_outstanding <= r_outstanding + CW'(w_req) - CW'(w_rsp);
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                r_pc     <= redirect_pc & ~32'd3;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_drop   <= r_outstanding - CW'(w_rsp);
            end else begin
                if (w_req) r_pc <= r_pc + 32'd4;
                if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
                if (w_keep) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
                r_count <= r_count + CW'(w_keep) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req) r_ifq[r_ifq_wr] <= imem_req_addr;
        if (w_keep) begin
            r_buf_instr[r_wr_ptr] <= imem_rsp_data;
            r_buf_pc[r_wr_ptr]    <= r_ifq[r_ifq_rd];
        end
    end

    assign if_valid = (r_count != '0);
    assign if_instr = if_valid ? r_buf_instr[r_rd_ptr] : '0;
    assign if_pc    = if_valid ? r_buf_pc[r_rd_ptr] : '0;
    assign opcode   = if_instr[31:26];
    assign rs       = if_instr[25:21];
    assign rt       = if_instr[20:16];
    assign rd       = if_instr[15:11];
    assign shamt    = if_instr[10:6];
    assign func     = if_instr[5:0];
    assign imm      = if_instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a queue-based fetch model predicts requests,
// deliveries and flushes; a second instance covers PC wrap from RESET_PC=FFFF_FFFC.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        id_ready       = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  func;
    logic [15:0] imm;

    logic        wr_req_valid;
    logic [31:0] wr_req_addr;
    logic        wr_if_valid;
    logic [31:0] wr_if_pc, wr_if_instr;
    logic [5:0]  wr_opcode, wr_func;
    logic [4:0]  wr_rs, wr_rt, wr_rd, wr_shamt;
    logic [15:0] wr_imm;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .func(func), .imm(imm)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(wr_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(wr_req_addr), .imem_rsp_valid(1'b0),
        .imem_rsp_data(32'h0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .id_ready(1'b1),
        .if_valid(wr_if_valid), .if_pc(wr_if_pc), .if_instr(wr_if_instr),
        .opcode(wr_opcode), .rs(wr_rs), .rt(wr_rt), .rd(wr_rd), .shamt(wr_shamt),
        .func(wr_func), .imm(wr_imm)
    );

    typedef struct packed { logic [31:0] addr; logic stale; } fly_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;

    fly_t        fly_q[$];
    ent_t        buf_q[$];
    logic [31:0] m_pc;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned dut_reqs = 0;
    logic [31:0] last_req_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        if (a == 32'h4) return 32'h0022_1820;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        fly_q.delete();
        buf_q.delete();
    endtask

    task automatic check_outputs(input bit redir, output bit exp_rv);
        ent_t e;
        exp_rv = !redir && ((buf_q.size() + fly_q.size()) < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(buf_q.size() != 0));
        e = (buf_q.size() != 0) ? buf_q[0] : '0;
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
        check("opcode", 32'(opcode), 32'(e.instr[31:26]));
        check("rs", 32'(rs), 32'(e.instr[25:21]));
        check("rt", 32'(rt), 32'(e.instr[20:16]));
        check("rd", 32'(rd), 32'(e.instr[15:11]));
        check("shamt", 32'(shamt), 32'(e.instr[10:6]));
        check("func", 32'(func), 32'(e.instr[5:0]));
        check("imm", 32'(imm), 32'(e.instr[15:0]));
    endtask

    task automatic step(input bit rdy, input bit rspv, input bit redir,
                        input logic [31:0] rpc, input bit idr);
        bit   exp_rv, rsp, pop;
        fly_t f;
        @(negedge clk);
        imem_req_ready = rdy;
        imem_rsp_valid = rspv;
        imem_rsp_data  = (fly_q.size() != 0) ? mem_word(fly_q[0].addr) : 32'hDEAD_BEEF;
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = idr;
        #1;
        check_outputs(redir, exp_rv);
        if (imem_req_valid && imem_req_ready) begin
            dut_reqs++;
            last_req_addr = imem_req_addr;
        end
        rsp = rspv && (fly_q.size() != 0);
        pop = (buf_q.size() != 0) && idr && !redir;
        f   = '0;
        if (rsp) f = fly_q.pop_front();
        if (redir) begin
            foreach (fly_q[i]) fly_q[i].stale = 1'b1;
            buf_q.delete();
            m_pc = rpc & ~32'd3;
        end else begin
            if (pop) void'(buf_q.pop_front());
            if (rsp && !f.stale) buf_q.push_back('{pc: f.addr, instr: mem_word(f.addr)});
            if (exp_rv && rdy) begin
                fly_q.push_back('{addr: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (fly_q.size() != 0 || buf_q.size() != 0); i++)
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_imm", 32'(imm), 32'h0);
        check("rst_wrap_req_valid", 32'(wr_req_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("wrap_valid0", 32'(wr_req_valid), 32'h1);
        check("wrap_addr0", wr_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        check("wrap_valid1", 32'(wr_req_valid), 32'h1);
        check("wrap_addr1", wr_req_addr, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("wrap_credit_stop", 32'(wr_req_valid), 32'h0);

        // Basic stream with 1-cycle responses
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        check("t1_pc0", if_pc, 32'h0);
        check("t1_op0", 32'(opcode), 32'h08);
        check("t1_imm0", 32'(imm), 32'h0005);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        check("t1_pc4", if_pc, 32'h4);
        check("t1_op4", 32'(opcode), 32'h00);
        check("t1_func4", 32'(func), 32'h20);
        check("t1_rd4", 32'(rd), 32'h3);
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Decode back-pressure
        drain();
        dut_reqs = 0;
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t2_reqs", dut_reqs, 32'd2);
        #1;
        check("t2_req_stop", 32'(imem_req_valid), 32'h0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect with two stale requests outstanding
        drain();
        step(1'b0, 1'b0, 1'b1, 32'h8, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
        dut_reqs = 0;
        for (int i = 0; i < 10 && dut_reqs == 0; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t3_addr", last_req_addr, 32'h40);
        for (int i = 0; i < 10 && !if_valid; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            #1;
        end
        check("t3_if_pc", if_pc, 32'h40);

        // Redirect coinciding with a response and a pop
        drain();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h103, 1'b1);
        #1;
        check("t4_flush", 32'(if_valid), 32'h0);
        dut_reqs = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t4_addr", last_req_addr, 32'h100);
        check("t4_reqs", dut_reqs, 32'd1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Asynchronous reset mid-flight
        drain();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        check("t6_pre_valid", 32'(if_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_if_valid", 32'(if_valid), 32'h0);
        check("t6_req_valid", 32'(imem_req_valid), 32'h0);
        check("t6_if_instr", if_instr, 32'h0);
        check("t6_if_pc", if_pc, 32'h0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        dut_reqs = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t6_first_addr", last_req_addr, RESET_PC);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0), rpc, 1'($urandom_range(0, 9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
